// File: rtl/mbist_pkg.sv
// Shared types for the March C- memory BIST controller: FSM states, op types
// and the per-element op/direction/data table.
package mbist_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;
   typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_e;

   localparam int unsigned NUM_ELEMS = 6;
   localparam int unsigned ELEM_W    = 3;

   // One march element: direction, op count, and up to two (op, data bit) pairs
   typedef struct packed {
      logic down;
      logic two;
      op_e  op0;
      logic d0;
      op_e  op1;
      logic d1;
   } elem_t;

   // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
   function automatic elem_t march_elem(input logic [ELEM_W-1:0] e);
      elem_t m;
      m = '0;
      case (e)
         3'd0: m = '{1'b0, 1'b0, OP_WRITE, 1'b0, OP_READ,  1'b0};
         3'd1: m = '{1'b0, 1'b1, OP_READ,  1'b0, OP_WRITE, 1'b1};
         3'd2: m = '{1'b0, 1'b1, OP_READ,  1'b1, OP_WRITE, 1'b0};
         3'd3: m = '{1'b1, 1'b1, OP_READ,  1'b0, OP_WRITE, 1'b1};
         3'd4: m = '{1'b1, 1'b1, OP_READ,  1'b1, OP_WRITE, 1'b0};
         3'd5: m = '{1'b0, 1'b0, OP_READ,  1'b0, OP_READ,  1'b0};
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Memory-under-test port bundle: controller is master, memory is slave.
interface mbist_march_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic                  mem_write_read;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (output mem_write_read, mem_address, mem_wdata, input mem_rdata);
   modport slave  (input mem_write_read, mem_address, mem_wdata, output mem_rdata);
endinterface

// File: rtl/mbist_cmp.sv
// Read-compare path: 2-stage expected-data pipeline aligned to the memory read
// latency, first-fail capture and saturating error counter.
module mbist_cmp #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  rd_v,
   input  logic [DATA_WIDTH-1:0] rd_exp,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [2:0]            rd_elem,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_elem,
   output logic [DATA_WIDTH-1:0] fail_rdata,
   output logic [7:0]            err_cnt
);
   logic                  v1_q, v2_q;
   logic [DATA_WIDTH-1:0] exp1_q, exp2_q;
   logic [ADDR_WIDTH-1:0] addr1_q, addr2_q;
   logic [2:0]            elem1_q, elem2_q;
   logic                  mismatch_c;

   assign mismatch_c = v2_q && (rdata != exp2_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         exp1_q  <= '0;
         exp2_q  <= '0;
         addr1_q <= '0;
         addr2_q <= '0;
         elem1_q <= '0;
         elem2_q <= '0;
      end else begin
         v1_q    <= rd_v;
         v2_q    <= v1_q;
         exp1_q  <= rd_exp;
         exp2_q  <= exp1_q;
         addr1_q <= rd_addr;
         addr2_q <= addr1_q;
         elem1_q <= rd_elem;
         elem2_q <= elem1_q;
      end
   end

   // Only the first mismatch of a run is captured; later ones just count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail       <= 1'b0;
         fail_addr  <= '0;
         fail_elem  <= '0;
         fail_rdata <= '0;
         err_cnt    <= '0;
      end else if (clr) begin
         fail       <= 1'b0;
         fail_addr  <= '0;
         fail_elem  <= '0;
         fail_rdata <= '0;
         err_cnt    <= '0;
      end else if (mismatch_c) begin
         if (!fail) begin
            fail_addr  <= addr2_q;
            fail_elem  <= elem2_q;
            fail_rdata <= rdata;
         end
         fail <= 1'b1;
         if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer: issues one memory op per cycle, tracks the run FSM
// and feeds each read's expected data into the compare pipeline.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned CAPACITY   = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_elem,
   output logic [DATA_WIDTH-1:0] fail_rdata,
   output logic [7:0]            err_cnt,
   mbist_march_ctrl_if.master    mem
);
   localparam logic [ADDR_WIDTH-1:0] CAP_A     = ADDR_WIDTH'(CAPACITY);
   localparam logic [ELEM_W-1:0]     LAST_ELEM = ELEM_W'(NUM_ELEMS - 1);

   state_e                state_q, state_d;
   logic [ELEM_W-1:0]     elem_q, elem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  opi_q, opi_d;
   logic [1:0]            drain_q, drain_d;
   logic                  busy_d, done_d, wr_d, rd_v_q, rd_v_d;
   logic [ADDR_WIDTH-1:0] maddr_d;
   logic [DATA_WIDTH-1:0] wdata_d, exp_q, exp_d;
   logic [2:0]            relem_q, relem_d;
   logic                  accept_c, issue_c, new_elem_c;
   logic                  op_last_c, addr_end_c, run_last_c, dbit_c;
   op_e                   op_c;
   elem_t                 cur_m, nxt_m;

   // Sequencer position (elem, addr, opi) names the op issued at the next edge
   always_comb begin
      state_d    = state_q;
      elem_d     = elem_q;
      addr_d     = addr_q;
      opi_d      = opi_q;
      drain_d    = drain_q;
      accept_c   = 1'b0;
      issue_c    = 1'b0;
      new_elem_c = 1'b0;
      wr_d       = 1'b0;
      maddr_d    = '0;
      wdata_d    = '0;
      rd_v_d     = 1'b0;
      exp_d      = '0;
      relem_d    = '0;
      cur_m      = march_elem(elem_q);
      op_c       = opi_q ? cur_m.op1 : cur_m.op0;
      dbit_c     = opi_q ? cur_m.d1 : cur_m.d0;
      op_last_c  = !cur_m.two || opi_q;
      addr_end_c = cur_m.down ? (addr_q == '0) : (addr_q == CAP_A);
      run_last_c = (elem_q == LAST_ELEM) && addr_end_c && op_last_c;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               accept_c = 1'b1;
               issue_c  = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            issue_c = 1'b1;
            drain_d = '0;
            if (run_last_c) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            drain_d = drain_q + 2'd1;
            if (drain_q == 2'd2) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (issue_c) begin
         wr_d    = (op_c == OP_WRITE);
         rd_v_d  = (op_c == OP_READ);
         maddr_d = addr_q;
         exp_d   = {DATA_WIDTH{dbit_c}};
         relem_d = elem_q;
         if (!op_last_c) begin
            opi_d = 1'b1;
         end else begin
            opi_d = 1'b0;
            if (!addr_end_c) begin
               addr_d = cur_m.down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
            end else begin
               new_elem_c = 1'b1;
               elem_d     = (elem_q == LAST_ELEM) ? '0 : elem_q + ELEM_W'(1);
            end
         end
      end

      // Write data leads the strobe by one cycle, so look one op ahead
      nxt_m = march_elem(elem_d);
      if (new_elem_c) addr_d = nxt_m.down ? CAP_A : '0;
      if (issue_c) wdata_d = {DATA_WIDTH{opi_d ? nxt_m.d1 : nxt_m.d0}};

      busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= ST_IDLE;
         elem_q             <= '0;
         addr_q             <= '0;
         opi_q              <= 1'b0;
         drain_q            <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         mem.mem_write_read <= 1'b0;
         mem.mem_address    <= '0;
         mem.mem_wdata      <= '0;
         rd_v_q             <= 1'b0;
         exp_q              <= '0;
         relem_q            <= '0;
      end else begin
         state_q            <= state_d;
         elem_q             <= elem_d;
         addr_q             <= addr_d;
         opi_q              <= opi_d;
         drain_q            <= drain_d;
         busy               <= busy_d;
         done               <= done_d;
         mem.mem_write_read <= wr_d;
         mem.mem_address    <= maddr_d;
         mem.mem_wdata      <= wdata_d;
         rd_v_q             <= rd_v_d;
         exp_q              <= exp_d;
         relem_q            <= relem_d;
      end
   end

   mbist_cmp #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_cmp (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (accept_c),
      .rd_v       (rd_v_q),
      .rd_exp     (exp_q),
      .rd_addr    (mem.mem_address),
      .rd_elem    (relem_q),
      .rdata      (mem.mem_rdata),
      .fail       (fail),
      .fail_addr  (fail_addr),
      .fail_elem  (fail_elem),
      .fail_rdata (fail_rdata),
      .err_cnt    (err_cnt)
   );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl: behavioural 16x8 memory with optional
// stuck-at and coupling faults, timing and address-trace checks.
module tb_mbist_march_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       busy, done, fail;
   logic [3:0] fail_addr;
   logic [2:0] fail_elem;
   logic [7:0] fail_rdata, err_cnt;

   int total = 0;
   int bad   = 0;
   int fault_mode = 0;

   logic [7:0] mem [0:15];
   logic [7:0] wd_q;
   logic [3:0] ra_q;

   logic       tr_wr   [0:400];
   logic [3:0] tr_addr [0:400];
   logic [7:0] tr_wd   [0:400];
   int         wcnt;
   logic       c1_fail, c1_done;
   logic [7:0] c1_err;
   int         dcyc;

   mbist_march_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) m ();

   mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(15)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .fail_addr  (fail_addr),
      .fail_elem  (fail_elem),
      .fail_rdata (fail_rdata),
      .err_cnt    (err_cnt),
      .mem        (m)
   );

   always #5 clk = ~clk;

   // Write to address 7 cannot change bit 5 while address 6 holds a 1 in bit 5
   function automatic logic [7:0] wr_val(input logic [3:0] a, input logic [7:0] d,
                                         input logic [7:0] old7, input logic [7:0] nb6);
      logic [7:0] v;
      v = d;
      if (fault_mode == 2 && a == 4'd7 && nb6[5]) v[5] = old7[5];
      return v;
   endfunction

   // Memory model: write data from previous cycle, read data two cycles after issue
   always @(posedge clk) begin
      wd_q <= m.mem_wdata;
      ra_q <= m.mem_address;
      if (m.mem_write_read)
         mem[m.mem_address] <= wr_val(m.mem_address, wd_q, mem[7], mem[6]);
      if (fault_mode == 1 && ra_q == 4'd5) m.mem_rdata <= mem[ra_q] | 8'h08;
      else                                 m.mem_rdata <= mem[ra_q];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Pulse start, record the bus per cycle until done (bounded), optional extra start
   task automatic run_test(input int extra_start);
      int cyc;
      wcnt = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1;
      c1_fail = fail;
      c1_done = done;
      c1_err  = err_cnt;
      while (!done && cyc < 400) begin
         tr_wr[cyc]   = m.mem_write_read;
         tr_addr[cyc] = m.mem_address;
         tr_wd[cyc]   = m.mem_wdata;
         if (cyc <= 160 && m.mem_write_read) wcnt++;
         start = (cyc == extra_start);
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
      dcyc = cyc;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  32'(busy), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_fail",  32'(fail), 0);
      chk("rst_err",   32'(err_cnt), 0);
      chk("rst_wr",    32'(m.mem_write_read), 0);
      chk("rst_wdata", 32'(m.mem_wdata), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fault-free run with an ignored start in cycle 20
      fault_mode = 0;
      run_test(20);
      chk("ff_done_cyc", 32'(dcyc), 163);
      chk("ff_busy_off", 32'(busy), 0);
      chk("ff_fail",     32'(fail), 0);
      chk("ff_err",      32'(err_cnt), 0);
      chk("ff_writes",   32'(wcnt), 80);
      chk("c1_wr",       32'(tr_wr[1]), 1);
      chk("c1_addr",     32'(tr_addr[1]), 0);
      chk("c1_wdata",    32'(tr_wd[1]), 0);
      chk("m1_first_addr", 32'(tr_addr[17]), 0);
      chk("m1_first_rd",   32'(tr_wr[17]), 0);
      chk("m1_wdata_lead", 32'(tr_wd[17]), 32'h0000_00FF);
      chk("m3_first_addr", 32'(tr_addr[81]), 15);
      chk("m3_last_addr",  32'(tr_addr[112]), 0);
      chk("m3_last_wr",    32'(tr_wr[112]), 1);
      chk("m5_last_addr",  32'(tr_addr[160]), 15);
      chk("post_run_wr",   32'(tr_wr[161]), 0);

      // Stuck-at-1 on bit 3 of address 5
      fault_mode = 1;
      run_test(0);
      chk("sa_done_cyc", 32'(dcyc), 163);
      chk("sa_fail",     32'(fail), 1);
      chk("sa_elem",     32'(fail_elem), 1);
      chk("sa_addr",     32'(fail_addr), 5);
      chk("sa_rdata",    32'(fail_rdata), 32'h08);
      chk("sa_err",      32'(err_cnt), 3);

      // Restart from DONE clears the previous result in cycle 1
      fault_mode = 0;
      run_test(0);
      chk("rr_c1_err",  32'(c1_err), 0);
      chk("rr_c1_fail", 32'(c1_fail), 0);
      chk("rr_c1_done", 32'(c1_done), 0);
      chk("rr_done_cyc", 32'(dcyc), 163);
      chk("rr_err",     32'(err_cnt), 0);

      // Coupling fault at address 7 (bad reads in M2 and M5)
      fault_mode = 2;
      run_test(0);
      chk("cp_fail",    32'(fail), 1);
      chk("cp_addr",    32'(fail_addr), 7);
      chk("cp_err_ge1", 32'(err_cnt >= 8'd1), 1);
      chk("cp_elem",    32'(fail_elem), 2);
      chk("cp_rdata",   32'(fail_rdata), 32'hDF);

      // Reset asserted in cycle 50 of a run
      fault_mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (49) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("ar_busy",  32'(busy), 0);
      chk("ar_done",  32'(done), 0);
      chk("ar_fail",  32'(fail), 0);
      chk("ar_err",   32'(err_cnt), 0);
      chk("ar_addr",  32'(m.mem_address), 0);
      chk("ar_wr",    32'(m.mem_write_read), 0);
      chk("ar_wdata", 32'(m.mem_wdata), 0);
      chk("ar_faddr", 32'(fail_addr), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_test(0);
      chk("ar_run_done_cyc", 32'(dcyc), 163);
      chk("ar_run_fail",     32'(fail), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
